// File: rtl/apb_target_timer_if.sv
// APB request/response bundle between the core's APB master bridge and a target.
//   paddr   : address (master -> target)
//   penable : access phase (master -> target)
//   psel    : target selected (master -> target)
//   pwrite  : 1=write, 0=read (master -> target)
//   pwdata  : write data (master -> target)
//   prdata  : read data, valid only while pready=1 (target -> master)
//   pready  : access-phase completion (target -> master)
//   perr    : error response, qualified by pready (target -> master)
interface apb_target_timer_if;
  logic [31:0] paddr;
  logic        penable;
  logic        psel;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        perr;

  modport master (
    output paddr, penable, psel, pwrite, pwdata,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, penable, psel, pwrite, pwdata,
    output prdata, pready, perr
  );
endinterface

// File: rtl/apb_target_timer.sv
// APB target holding a 64-bit prescaled free-running timer, a 64-bit comparator and a sticky
// match flag driving a registered interrupt. Programmable wait states stall each access.
//   clk       : clock
//   reset_n   : asynchronous active-low reset
//   apb       : APB slave port (paddr[4:2] decoded; 6 and 7 respond with perr)
//   timer_irq : match & CTRL.irq_en, registered
module apb_target_timer #(
  parameter int unsigned WAIT_STATES    = 0,
  parameter logic [7:0]  RESET_PRESCALE = 8'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  apb_target_timer_if.slave apb,
  output logic              timer_irq
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;

  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  presc_cnt_q, presc_cnt_d;
  logic [63:0] timer_q, timer_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic        match_q, match_d;
  logic        irq_q;

  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        rerr;

  logic unused_paddr;
  assign unused_paddr = ^{apb.paddr[31:5], apb.paddr[1:0]};

  // Transfer FSM; address/control are latched in the setup phase.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    ready      = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // psel&penable without a setup phase is a protocol violation and is ignored.
        if (apb.psel && !apb.penable) begin
          state_d    = StAccess;
          wait_cnt_d = WaitInit;
          addr_d     = apb.paddr[4:2];
          write_d    = apb.pwrite;
          wdata_d    = apb.pwdata;
        end
      end
      StAccess: begin
        ready = (wait_cnt_q == 4'd0);
        if (!apb.psel) begin
          state_d = StIdle;  // master abort: nothing commits
        end else if (apb.penable) begin
          if (ready) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic wr, rd, presc_hit;
  assign wr        = done & write_q;
  assign rd        = done & ~write_q;
  assign presc_hit = (presc_cnt_q == prescale_q);

  // Register next-state. Later assignments take priority: APB timer writes beat the
  // increment, and the match set beats a same-cycle W1C.
  always_comb begin
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    prescale_d  = prescale_q;
    presc_cnt_d = presc_cnt_q;
    timer_d     = timer_q;
    cmp_d       = cmp_q;
    hi_snap_d   = hi_snap_q;
    match_d     = match_q;

    if (enable_q) begin
      presc_cnt_d = presc_hit ? 8'd0 : presc_cnt_q + 8'd1;
      if (presc_hit) timer_d = timer_q + 64'd1;
    end

    if (wr) begin
      unique case (addr_q)
        3'd0: begin
          enable_d    = wdata_q[0];
          irq_en_d    = wdata_q[1];
          prescale_d  = wdata_q[15:8];
          presc_cnt_d = 8'd0;
        end
        3'd1:    if (wdata_q[0]) match_d = 1'b0;
        3'd2:    timer_d = {timer_q[63:32], wdata_q};
        3'd3:    timer_d = {wdata_q, timer_q[31:0]};
        3'd4:    cmp_d[31:0]  = wdata_q;
        3'd5:    cmp_d[63:32] = wdata_q;
        default: ;
      endcase
    end

    // Reading TIMER_LO freezes the upper half so a following TIMER_HI read is coherent.
    if (rd && (addr_q == 3'd2)) hi_snap_d = timer_q[63:32];

    if (timer_q >= cmp_q) match_d = 1'b1;
  end

  // Read mux from latched address and current register values.
  always_comb begin
    rdata = 32'd0;
    rerr  = 1'b0;
    unique case (addr_q)
      3'd0:       rdata = {16'd0, prescale_q, 6'd0, irq_en_q, enable_q};
      3'd1:       rdata = {31'd0, match_q};
      3'd2:       rdata = timer_q[31:0];
      3'd3:       rdata = hi_snap_q;
      3'd4:       rdata = cmp_q[31:0];
      3'd5:       rdata = cmp_q[63:32];
      3'd6, 3'd7: rerr  = 1'b1;
      default:    rerr  = 1'b1;
    endcase
  end

  assign apb.pready = ready;
  assign apb.prdata = ready ? rdata : 32'd0;
  assign apb.perr   = ready & rerr;
  assign timer_irq  = irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wait_cnt_q  <= 4'd0;
      addr_q      <= 3'd0;
      write_q     <= 1'b0;
      wdata_q     <= 32'd0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      prescale_q  <= RESET_PRESCALE;
      presc_cnt_q <= 8'd0;
      timer_q     <= 64'd0;
      cmp_q       <= 64'd0;
      hi_snap_q   <= 32'd0;
      match_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      timer_q     <= timer_d;
      cmp_q       <= cmp_d;
      hi_snap_q   <= hi_snap_d;
      match_q     <= match_d;
      irq_q       <= match_q & irq_en_q;
    end
  end

endmodule

// File: tb/tb_apb_target_timer.sv
// Bench for apb_target_timer: one zero-wait instance and one three-wait instance share a
// request bus; each has its own psel. Reads push expected {perr, prdata} to a scoreboard
// and the observed completion is pushed alongside, then each test drains and compares.
module tb_apb_target_timer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic        sel0 = 1'b0;
  logic        sel3 = 1'b0;
  logic        irq0, irq3;

  apb_target_timer_if bus0();
  apb_target_timer_if bus3();

  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.psel    = sel0;
  assign bus3.paddr   = paddr;
  assign bus3.pwdata  = pwdata;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.psel    = sel3;

  apb_target_timer #(.WAIT_STATES(0), .RESET_PRESCALE(8'h00)) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .apb       (bus0.slave),
    .timer_irq (irq0)
  );

  apb_target_timer #(.WAIT_STATES(3), .RESET_PRESCALE(8'h05)) dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .apb       (bus3.slave),
    .timer_irq (irq3)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  string       nm_q[$];

  // One APB transfer starting #1 after an edge; returns #1 after the completion edge.
  task automatic xfer(input bit d3, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, output logic [31:0] rd_data,
                      output logic rd_err, output int waits);
    bit got;
    waits = 0;
    got = 1'b0;
    rd_data = 'x;
    rd_err = 1'bx;
    paddr = addr;
    pwrite = wr;
    pwdata = wd;
    penable = 1'b0;
    if (d3) sel3 = 1'b1; else sel0 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 32 && !got; i++) begin
      if (d3 ? bus3.pready : bus0.pready) begin
        rd_data = d3 ? bus3.prdata : bus0.prdata;
        rd_err = d3 ? bus3.perr : bus0.perr;
        got = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    sel0 = 1'b0;
    sel3 = 1'b0;
    penable = 1'b0;
  endtask

  task automatic rd(input bit d3, input logic [31:0] addr, input string nm,
                    input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic        e;
    int          w;
    exp_q.push_back({exp_err, exp_data});
    nm_q.push_back(nm);
    xfer(d3, addr, 1'b0, 32'd0, d, e, w);
    got_q.push_back({e, d});
  endtask

  task automatic wr(input bit d3, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    int          w;
    xfer(d3, addr, 1'b1, data, d, e, w);
  endtask

  task automatic test_reset();
    logic [32:0] e, g;
    string n;
    logic [31:0] d;
    logic er;
    int w;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus0.pready, bus0.perr, bus0.prdata, irq0, bus3.pready, irq3} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {bus0.pready, bus0.perr, bus0.prdata, irq0, bus3.pready, irq3});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h0, 1'b0, 32'd0, d, er, w);
    vectors++;
    if (w !== 0 || d !== 32'd0 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl_first_access: got waits=%0d data=%h err=%0b, expected 0/0/0",
               w, d, er);
    end
    // cmp resets to 0, so timer>=cmp holds from the first cycle and match is already set.
    rd(1'b0, 32'h4, "reset_status", 32'd1, 1'b0);
    rd(1'b0, 32'h8, "reset_timer_lo", 32'd0, 1'b0);
    rd(1'b1, 32'h0, "reset_ctrl_prescale", 32'h0000_0500, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got err=%0b data=%h, expected err=%0b data=%h", n, g[32], g[31:0],
                 e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_count();
    logic [32:0] e, g;
    string n;
    wr(1'b0, 32'h0, 32'h0000_0001);
    // Timer is k after the k-th edge following the CTRL write; the read samples one edge later.
    repeat (10) @(posedge clk);
    #1;
    rd(1'b0, 32'h8, "timer_count_prescale0", 32'd11, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got err=%0b data=%h, expected err=%0b data=%h", n, g[32], g[31:0],
                 e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_coherent();
    logic [32:0] e, g;
    string n;
    wr(1'b0, 32'h0, 32'h0);
    wr(1'b0, 32'hC, 32'h1);
    wr(1'b0, 32'h8, 32'hFFFF_FFFE);
    wr(1'b0, 32'h0, 32'h1);
    rd(1'b0, 32'h8, "coherent_lo_1", 32'hFFFF_FFFF, 1'b0);
    rd(1'b0, 32'hC, "coherent_hi_1", 32'h1, 1'b0);
    rd(1'b0, 32'h8, "coherent_lo_2", 32'h0000_0003, 1'b0);
    rd(1'b0, 32'hC, "coherent_hi_2", 32'h2, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got err=%0b data=%h, expected err=%0b data=%h", n, g[32], g[31:0],
                 e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_match();
    logic [32:0] e, g;
    string n;
    int cyc;
    int exp_cyc;
    wr(1'b0, 32'h0, 32'h0);
    wr(1'b0, 32'h8, 32'h0);
    wr(1'b0, 32'hC, 32'h0);
    wr(1'b0, 32'h10, 32'h20);
    wr(1'b0, 32'h14, 32'h0);
    wr(1'b0, 32'h4, 32'h1);
    rd(1'b0, 32'h4, "status_cleared", 32'd0, 1'b0);
    vectors++;
    if (irq0 !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_before_enable: got %0b, expected 0", irq0);
    end
    wr(1'b0, 32'h0, 32'h0000_0103);
    // prescale 1: timer reaches 0x20 after 2*0x20 edges, match one edge later, irq one more.
    exp_cyc = 2 * 32'h20 + 2;
    cyc = 0;
    for (int i = 1; i <= 200 && cyc == 0; i++) begin
      @(posedge clk); #1;
      if (irq0 === 1'b1) cyc = i;
    end
    vectors++;
    if (cyc !== exp_cyc) begin
      miscompares++;
      $display("FAIL irq_rise_cycle: got %0d, expected %0d", cyc, exp_cyc);
    end
    rd(1'b0, 32'h4, "status_match_set", 32'd1, 1'b0);
    wr(1'b0, 32'h4, 32'h1);
    rd(1'b0, 32'h4, "status_w1c_set_wins", 32'd1, 1'b0);
    vectors++;
    if (irq0 !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_held: got %0b, expected 1", irq0);
    end
    wr(1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    vectors++;
    if (irq0 !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_after_irq_en_clear: got %0b, expected 0", irq0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got err=%0b data=%h, expected err=%0b data=%h", n, g[32], g[31:0],
                 e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e, g;
    string n;
    wr(1'b0, 32'h10, 32'hA5A5_0001);
    wr(1'b0, 32'h14, 32'h5A5A_0002);
    rd(1'b0, 32'h10, "b2b_cmp_lo", 32'hA5A5_0001, 1'b0);
    rd(1'b0, 32'h14, "b2b_cmp_hi", 32'h5A5A_0002, 1'b0);
    rd(1'b0, 32'h0, "b2b_ctrl", 32'h0, 1'b0);
    rd(1'b0, 32'h38, "b2b_addr6_err", 32'h0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got err=%0b data=%h, expected err=%0b data=%h", n, g[32], g[31:0],
                 e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [32:0] e, g;
    string n;
    logic [31:0] d;
    logic er;
    int w;
    logic rdy_seen;
    xfer(1'b1, 32'h10, 1'b1, 32'h0000_1234, d, er, w);
    vectors++;
    if (w !== 3 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_write: got waits=%0d err=%0b, expected 3/0", w, er);
    end
    xfer(1'b1, 32'h10, 1'b0, 32'd0, d, er, w);
    vectors++;
    if (w !== 3 || d !== 32'h0000_1234 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_read: got waits=%0d data=%h err=%0b, expected 3/00001234/0", w, d, er);
    end
    // Abort a write mid-wait by dropping psel.
    paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h0000_DEAD; penable = 1'b0; sel3 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    rdy_seen = bus3.pready;
    @(posedge clk); #1;
    rdy_seen = rdy_seen | bus3.pready;
    sel3 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (rdy_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pready: got %0b, expected 0", rdy_seen);
    end
    rd(1'b1, 32'h10, "cmp_lo_after_abort", 32'h0000_1234, 1'b0);
    rd(1'b1, 32'h18, "wait_addr6_err", 32'h0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got err=%0b data=%h, expected err=%0b data=%h", n, g[32], g[31:0],
                 e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_error_reset();
    logic [32:0] e, g;
    string n;
    logic [31:0] d;
    logic er;
    int w;
    xfer(1'b0, 32'h18, 1'b0, 32'd0, d, er, w);
    vectors++;
    if (w !== 0 || d !== 32'd0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL err_read_0x18: got waits=%0d data=%h err=%0b, expected 0/0/1", w, d, er);
    end
    xfer(1'b0, 32'h1C, 1'b1, 32'hFFFF_FFFF, d, er, w);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL err_write_0x1c: got err=%0b, expected 1", er);
    end
    rd(1'b0, 32'h0, "ctrl_after_bad_write", 32'h0, 1'b0);
    wr(1'b0, 32'h0, 32'h0000_0702);
    // Reset in the middle of a waited access on dut3.
    paddr = 32'h10; pwrite = 1'b0; penable = 1'b0; sel3 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus3.pready, bus3.perr, bus3.prdata, bus0.pready, irq0, irq3} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_mid_access_outputs: got %h, expected 0",
               {bus3.pready, bus3.perr, bus3.prdata, bus0.pready, irq0, irq3});
    end
    sel3 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(1'b0, 32'h0, "post_reset_ctrl", 32'h0, 1'b0);
    rd(1'b0, 32'h10, "post_reset_cmp_lo", 32'h0, 1'b0);
    rd(1'b0, 32'h14, "post_reset_cmp_hi", 32'h0, 1'b0);
    rd(1'b0, 32'h8, "post_reset_timer_lo", 32'h0, 1'b0);
    rd(1'b0, 32'h4, "post_reset_status", 32'h1, 1'b0);
    rd(1'b1, 32'h10, "post_reset_dut3_cmp_lo", 32'h0, 1'b0);
    rd(1'b1, 32'h0, "post_reset_dut3_ctrl", 32'h0000_0500, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got err=%0b data=%h, expected err=%0b data=%h", n, g[32], g[31:0],
                 e[32], e[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_coherent();
    test_match();
    test_back_to_back();
    test_wait_states();
    test_error_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
